dt_thermo_walker: RTL

//  Programmable, sequential decision-tree classifier. Walks a node table loaded at
//  run time, one node per clock, and returns a thermometer-coded leaf result.

---
 rtl/dt_thermo_walker.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dt_thermo_walker.sv
// -----------------------------------------------------------------------------
// dt_thermo_walker
//
// Programmable sequential decision-tree classifier. A node table held in a
// register array is walked one node per clock starting at address 0. Internal
// nodes select a feature bit and branch to child (bit = 0) or child+1 (bit = 1).
// Leaf nodes end the walk with a thermometer code of k ones. A walk that visits
// MAX_STEPS internal nodes without reaching a leaf ends as a timeout
// (out_err = 1, out_therm = 0). Only one sample is in flight at a time.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   cfg_we     : node-table write strobe (ignored while cfg_busy)
//   cfg_addr   : node-table write address
//   cfg_wdata  : node word {is_leaf, field[IDX_W-1:0], child[ADDR_W-1:0]}
//   cfg_busy   : high while a walk or an unconsumed result is pending
//   in_valid   : sample valid
//   in_ready   : block can accept a sample (IDLE only)
//   in_feat    : binary feature vector
//   out_valid  : result valid
//   out_ready  : consumer accepts the result
//   out_therm  : thermometer-coded result
//   out_err    : result is a timeout
// -----------------------------------------------------------------------------
module dt_thermo_walker #(
  parameter int FEAT_W    = 13,
  parameter int OUT_W     = 13,
  parameter int ADDR_W    = 8,
  parameter int MAX_STEPS = 16,
  parameter int IDX_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [ADDR_W-1:0]       cfg_addr,
  input  logic [IDX_W+ADDR_W:0]   cfg_wdata,
  output logic                    cfg_busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FEAT_W-1:0]       in_feat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_therm,
  output logic                    out_err
);

  localparam int NODE_W = 1 + IDX_W + ADDR_W;
  localparam int DEPTH  = 2 ** ADDR_W;
  // Steps counter must be able to hold MAX_STEPS itself.
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [NODE_W-1:0]   node_mem [DEPTH];
  logic [ADDR_W-1:0]   cur;
  logic [STEP_W-1:0]   steps;
  logic [FEAT_W-1:0]   feat_q;

  logic [NODE_W-1:0]   node;
  logic                node_leaf;
  logic [IDX_W-1:0]    node_field;
  logic [ADDR_W-1:0]   node_child;
  logic                branch_bit;

  logic                accept;
  logic                leaf_hit;
  logic                timeout;

  // ---------------------------------------------------------------------------
  // Feature select: indices beyond the feature vector read as 0.
  // ---------------------------------------------------------------------------
  function automatic logic feat_bit(input logic [FEAT_W-1:0] v,
                                    input logic [IDX_W-1:0]  f);
    logic b;
    b = 1'b0;
    for (int i = 0; i < FEAT_W; i++) begin
      if (int'(f) == i) b = v[i];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Thermometer code with k low bits set; k beyond OUT_W saturates to all ones.
  // ---------------------------------------------------------------------------
  function automatic logic [OUT_W-1:0] therm_code(input logic [IDX_W-1:0] k);
    logic [OUT_W-1:0] t;
    t = '0;
    for (int i = 0; i < OUT_W; i++) begin
      t[i] = (i < int'(k));
    end
    return t;
  endfunction

  // Current node decode (combinational table read).
  assign node       = node_mem[cur];
  assign node_leaf  = node[NODE_W-1];
  assign node_field = node[ADDR_W +: IDX_W];
  assign node_child = node[ADDR_W-1:0];
  assign branch_bit = feat_bit(feat_q, node_field);

  assign accept   = (state == S_IDLE) && in_valid;
  assign leaf_hit = (state == S_WALK) && node_leaf;
  // The node being inspected is the last one allowed; if it is internal too,
  // the walk gives up.
  assign timeout  = (state == S_WALK) && !node_leaf && (steps == LAST_STEP);

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign cfg_busy  = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept)             state_nxt = S_WALK;
      S_WALK: if (leaf_hit || timeout) state_nxt = S_DONE;
      S_DONE: if (out_ready)          state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Node table: writes only land while idle, so a walk always sees a frozen
  // tree. A write coincident with an accept lands before the first node read.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (cfg_we && (state == S_IDLE)) node_mem[cfg_addr] <= cfg_wdata;
  end

  // ---------------------------------------------------------------------------
  // Sample latch (data only, no reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) feat_q <= in_feat;
  end

  // ---------------------------------------------------------------------------
  // Walk pointer, step count and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= '0;
      steps     <= '0;
      out_therm <= '0;
      out_err   <= 1'b0;
    end else begin
      if (accept) begin
        cur   <= '0;
        steps <= '0;
      end else if ((state == S_WALK) && !node_leaf) begin
        // Address arithmetic wraps modulo the table size.
        cur   <= node_child + ADDR_W'(branch_bit);
        steps <= steps + STEP_W'(1);
      end

      if (leaf_hit) begin
        out_therm <= therm_code(node_field);
        out_err   <= 1'b0;
      end else if (timeout) begin
        out_therm <= '0;
        out_err   <= 1'b1;
      end
    end
  end

endmodule
